// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch and data requester ports plus the shared memory port.
// The arbiter uses the slave modport; the environment (requesters and memory) uses master.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Fetch requester
    logic                  if_en;
    logic [ADDR_W-1:0]     if_addr;
    logic [DATA_W-1:0]     if_rdata;
    logic                  if_rdata_valid;

    // MEM-stage data requester
    logic                  dm_en;
    logic                  dm_we;
    logic [ADDR_W-1:0]     dm_addr;
    logic [DATA_W/8-1:0]   dm_wmask;
    logic [DATA_W-1:0]     dm_wdata;
    logic [DATA_W-1:0]     dm_rdata;
    logic                  dm_rdata_valid;
    logic                  dm_write_finish;

    // Downstream memory / bridge
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rdata_valid;
    logic                  mem_write_finish;

    modport slave (
        input  if_en, if_addr,
        output if_rdata, if_rdata_valid,
        input  dm_en, dm_we, dm_addr, dm_wmask, dm_wdata,
        output dm_rdata, dm_rdata_valid, dm_write_finish,
        output mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
        input  mem_rdata, mem_rdata_valid, mem_write_finish
    );

    modport master (
        output if_en, if_addr,
        input  if_rdata, if_rdata_valid,
        output dm_en, dm_we, dm_addr, dm_wmask, dm_wdata,
        input  dm_rdata, dm_rdata_valid, dm_write_finish,
        input  mem_en, mem_we, mem_addr, mem_wmask, mem_wdata,
        output mem_rdata, mem_rdata_valid, mem_write_finish
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-style memory port between fetch (read-only) and MEM-stage load/store.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed priority, dm over if.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    output logic              busy,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned MaskW = DATA_W / 8;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StIfBusy = 2'd1,
        StDmBusy = 2'd2
    } state_e;

    typedef enum logic {
        GrantIf = 1'b0,
        GrantDm = 1'b1
    } grant_e;

    state_e            state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              discard_q, discard_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [MaskW-1:0]  wmask_q, wmask_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pick_dm;
    logic              resp;
    logic              fwd;

    // Arbitration policy, only meaningful when at least one request is pending.
    always_comb begin
        pick_dm = bus.dm_en;
`ifdef MEM_ARB_RR_EN
        if (bus.dm_en && bus.if_en) begin
            pick_dm = (last_grant_q == GrantIf);
        end
`endif
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        discard_d    = discard_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wmask_d      = wmask_q;
        wdata_d      = wdata_q;
        resp         = 1'b0;
        fwd          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!flush && (bus.if_en || bus.dm_en)) begin
                    if (pick_dm) begin
                        state_d      = StDmBusy;
                        last_grant_d = GrantDm;
                        we_d         = bus.dm_we;
                        addr_d       = bus.dm_addr;
                        wmask_d      = bus.dm_wmask;
                        wdata_d      = bus.dm_wdata;
                    end else begin
                        state_d      = StIfBusy;
                        last_grant_d = GrantIf;
                        we_d         = 1'b0;
                        addr_d       = bus.if_addr;
                        wmask_d      = '0;
                        wdata_d      = '0;
                    end
                end
            end
            StIfBusy, StDmBusy: begin
                // Stores complete on write_finish, everything else on rdata_valid.
                resp = (state_q == StDmBusy && we_q) ? bus.mem_write_finish
                                                     : bus.mem_rdata_valid;
                if (resp) begin
                    fwd       = !discard_q && !flush;
                    state_d   = StIdle;
                    discard_d = 1'b0;
                end else if (flush) begin
                    discard_d = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy                = (state_q != StIdle);
        bus.mem_en          = (state_q != StIdle);
        bus.mem_we          = we_q;
        bus.mem_addr        = addr_q;
        bus.mem_wmask       = wmask_q;
        bus.mem_wdata       = wdata_q;
        bus.if_rdata        = bus.mem_rdata;
        bus.dm_rdata        = bus.mem_rdata;
        bus.if_rdata_valid  = fwd && (state_q == StIfBusy);
        bus.dm_rdata_valid  = fwd && (state_q == StDmBusy) && !we_q;
        bus.dm_write_finish = fwd && (state_q == StDmBusy) && we_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantIf;
            discard_q    <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wmask_q      <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            discard_q    <= discard_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wmask_q      <= wmask_d;
            wdata_q      <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then randomized requests,
// checked against a transaction-level model of the arbitration and response rules.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic busy;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    bit          lg_dm;
    bit          granted;
    bit          g_dm;
    bit          g_we;
    logic [31:0] g_addr;
    logic [3:0]  g_wmask;
    logic [31:0] g_wdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_resp();
        bus.mem_rdata_valid  = 1'b0;
        bus.mem_write_finish = 1'b0;
        flush                = 1'b0;
    endtask

    // One cycle in IDLE: checks idle outputs, predicts the grant taken at the next edge.
    task automatic idle_cycle(input bit fl, input bit spur);
        flush = fl;
        if (spur) begin
            bus.mem_rdata_valid  = 1'($urandom_range(0, 1));
            bus.mem_write_finish = !bus.mem_rdata_valid;
            bus.mem_rdata        = $urandom;
        end
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_mem_en", 64'(bus.mem_en), 64'd0);
        chk("idle_pulses", 64'({bus.if_rdata_valid, bus.dm_rdata_valid, bus.dm_write_finish}),
            64'd0);
        granted = !fl && (bus.if_en || bus.dm_en);
        if (granted) begin
            if (bus.if_en && bus.dm_en) begin
`ifdef MEM_ARB_RR_EN
                g_dm = !lg_dm;
`else
                g_dm = 1'b1;
`endif
            end else begin
                g_dm = bus.dm_en;
            end
            if (g_dm) begin
                g_we    = bus.dm_we;
                g_addr  = bus.dm_addr;
                g_wmask = bus.dm_wmask;
                g_wdata = bus.dm_wdata;
            end else begin
                g_we    = 1'b0;
                g_addr  = bus.if_addr;
                g_wmask = 4'd0;
                g_wdata = 32'd0;
            end
            lg_dm = g_dm;
        end
        tick();
        clear_resp();
    endtask

    // Busy phase of a granted transaction: lat waiting cycles then the response cycle.
    task automatic busy_txn(input int lat, input int fl_at, input bit scramble,
                            input logic [31:0] rd);
        bit disc;
        bit fwd;
        disc = 1'b0;
        for (int k = 0; k <= lat; k++) begin
            flush = (k == fl_at);
            if (scramble && k > 0) begin
                if (g_dm) begin
                    bus.dm_addr  = 32'hdeadbeef;
                    bus.dm_wdata = $urandom;
                    bus.dm_wmask = 4'($urandom);
                    bus.dm_we    = 1'($urandom);
                    if ($urandom_range(0, 3) == 0) bus.dm_en = 1'b0;
                end else begin
                    bus.if_addr = 32'hdeadbeef;
                    if ($urandom_range(0, 3) == 0) bus.if_en = 1'b0;
                end
            end
            if (k == lat) begin
                bus.mem_rdata = rd;
                if (g_we) bus.mem_write_finish = 1'b1;
                else      bus.mem_rdata_valid  = 1'b1;
            end
            #1;
            chk("busy", 64'(busy), 64'd1);
            chk("mem_en", 64'(bus.mem_en), 64'd1);
            chk("mem_addr", 64'(bus.mem_addr), 64'(g_addr));
            chk("mem_we", 64'(bus.mem_we), 64'(g_we));
            chk("mem_wmask", 64'(bus.mem_wmask), 64'(g_wmask));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(g_wdata));
            fwd = (k == lat) && !disc && !flush;
            chk("if_rdata_valid", 64'(bus.if_rdata_valid), 64'(fwd && !g_dm));
            chk("dm_rdata_valid", 64'(bus.dm_rdata_valid), 64'(fwd && g_dm && !g_we));
            chk("dm_write_finish", 64'(bus.dm_write_finish), 64'(fwd && g_dm && g_we));
            if (fwd) begin
                if (g_dm) chk("dm_rdata", 64'(bus.dm_rdata), 64'(rd));
                else      chk("if_rdata", 64'(bus.if_rdata), 64'(rd));
            end
            if (k < lat && flush) disc = 1'b1;
            tick();
            clear_resp();
        end
        if (g_dm) bus.dm_en = 1'b0;
        else      bus.if_en = 1'b0;
    endtask

    initial begin
        reset                = 1'b1;
        flush                = 1'b0;
        bus.if_en            = 1'b0;
        bus.if_addr          = '0;
        bus.dm_en            = 1'b0;
        bus.dm_we            = 1'b0;
        bus.dm_addr          = '0;
        bus.dm_wmask         = '0;
        bus.dm_wdata         = '0;
        bus.mem_rdata        = '0;
        bus.mem_rdata_valid  = 1'b0;
        bus.mem_write_finish = 1'b0;
        lg_dm                = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we), 64'd0);
        chk("rst_mem_wmask", 64'(bus.mem_wmask), 64'd0);
        chk("rst_mem_wdata", 64'(bus.mem_wdata), 64'd0);
        chk("rst_pulses", 64'({bus.if_rdata_valid, bus.dm_rdata_valid, bus.dm_write_finish}),
            64'd0);

        // Single fetch, response 3 cycles after mem_en
        bus.if_en   = 1'b1;
        bus.if_addr = 32'h1c000000;
        idle_cycle(1'b0, 1'b0);
        busy_txn(3, -1, 1'b0, 32'h02800c0c);

        // Contention: both in the same cycle, loser follows after one bubble
        bus.if_en    = 1'b1;
        bus.if_addr  = 32'h1c000040;
        bus.dm_en    = 1'b1;
        bus.dm_we    = 1'b0;
        bus.dm_addr  = 32'h1c010004;
        idle_cycle(1'b0, 1'b0);
        busy_txn(1, -1, 1'b0, $urandom);
        idle_cycle(1'b0, 1'b0);
        busy_txn(2, -1, 1'b0, $urandom);

        // Store
        bus.dm_en    = 1'b1;
        bus.dm_we    = 1'b1;
        bus.dm_addr  = 32'h1c010002;
        bus.dm_wmask = 4'b1100;
        bus.dm_wdata = 32'habcd0000;
        idle_cycle(1'b0, 1'b0);
        busy_txn(2, -1, 1'b0, $urandom);

        // Contention again with last grant = dm (policy-dependent winner)
        bus.if_en   = 1'b1;
        bus.if_addr = 32'h1c000080;
        bus.dm_en   = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h1c010010;
        idle_cycle(1'b0, 1'b0);
        busy_txn(0, -1, 1'b0, $urandom);
        idle_cycle(1'b0, 1'b0);
        busy_txn(1, -1, 1'b0, $urandom);

        // Flush in flight: flush one cycle after grant, response two cycles later
        bus.if_en   = 1'b1;
        bus.if_addr = 32'h1c000100;
        idle_cycle(1'b0, 1'b0);
        busy_txn(3, 1, 1'b0, $urandom);

        // Flush in IDLE blocks acceptance, spurious response ignored
        bus.dm_en   = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h1c010020;
        idle_cycle(1'b1, 1'b1);
        idle_cycle(1'b0, 1'b0);
        // Requester inputs change after grant
        busy_txn(3, -1, 1'b1, $urandom);

        // Reset mid-transaction
        bus.dm_en   = 1'b1;
        bus.dm_we   = 1'b0;
        bus.dm_addr = 32'h1c010030;
        idle_cycle(1'b0, 1'b0);
        chk("pre_rst_mem_en", 64'(bus.mem_en), 64'd1);
        reset     = 1'b1;
        bus.dm_en = 1'b0;
        tick();
        reset = 1'b0;
        lg_dm = 1'b0;
        chk("mid_rst_mem_en", 64'(bus.mem_en), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'h12345678;
        #1;
        chk("late_resp", 64'({bus.if_rdata_valid, bus.dm_rdata_valid, bus.dm_write_finish}),
            64'd0);
        tick();
        clear_resp();

        // Randomized traffic
        for (int r = 0; r < 150; r++) begin
            if (!bus.if_en && $urandom_range(0, 2) != 0) begin
                bus.if_en   = 1'b1;
                bus.if_addr = $urandom;
            end
            if (!bus.dm_en && $urandom_range(0, 2) != 0) begin
                bus.dm_en    = 1'b1;
                bus.dm_we    = 1'($urandom);
                bus.dm_addr  = $urandom;
                bus.dm_wmask = 4'($urandom);
                bus.dm_wdata = $urandom;
            end
            idle_cycle($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0);
            if (granted) begin
                busy_txn($urandom_range(0, 4),
                         ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                         1'($urandom), $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
